// File: rtl/impulse_sequencer_pkg.sv
// Shared types and widths for the impulse sequencer.
//   state_e  : sequencer FSM states
//   prm_t    : latched SPI parameter packet
//   eff_period() : pulse period with the zero case mapped to one clock
package imp_seq_pkg;

  localparam int unsigned TIME_W = 64;
  localparam int unsigned FREQ_W = 48;
  localparam int unsigned INT_W  = 32;
  localparam int unsigned NIMP_W = 16;
  localparam int unsigned TYPE_W = 8;

  // TYPE_impulse bit positions; bits 7:1 are latched but reserved
  localparam int unsigned TYPE_CONT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic [FREQ_W-1:0] freq_step;
    logic [INT_W-1:0]  freq_rate;
    logic [TIME_W-1:0] time_start;
    logic [NIMP_W-1:0] n_impulse;
    logic [TYPE_W-1:0] type_impulse;
    logic [INT_W-1:0]  ti;
    logic [INT_W-1:0]  tp;
    logic [INT_W-1:0]  tblank1;
    logic [INT_W-1:0]  tblank2;
  } prm_t;

  // A zero period would never let a pulse complete; run it as one clock
  function automatic logic [INT_W-1:0] eff_period(input logic [INT_W-1:0] tp);
    return (tp == '0) ? INT_W'(1) : tp;
  endfunction

endpackage

// File: rtl/impulse_sequencer_if.sv
// Parameter-packet / pulse-output bus of the impulse sequencer.
//   master : packet source (decoder side), observes the sequencer outputs
//   slave  : impulse_sequencer
interface impulse_sequencer_if;
  import imp_seq_pkg::*;

  logic              SPI_WR;
  logic              SYS_TIME_UPDATE;
  logic [TIME_W-1:0] TIME;
  logic [FREQ_W-1:0] FREQ;
  logic [FREQ_W-1:0] FREQ_STEP;
  logic [INT_W-1:0]  FREQ_RATE;
  logic [TIME_W-1:0] TIME_START;
  logic [NIMP_W-1:0] N_impulse;
  logic [TYPE_W-1:0] TYPE_impulse;
  logic [INT_W-1:0]  Interval_Ti;
  logic [INT_W-1:0]  Interval_Tp;
  logic [INT_W-1:0]  Tblank1;
  logic [INT_W-1:0]  Tblank2;

  logic [TIME_W-1:0] SYS_TIME;
  logic              IMP;
  logic              BLANK;
  logic [FREQ_W-1:0] FREQ_OUT;
  logic              FREQ_VALID;
  logic              BUSY;
  logic              DONE;

  modport master (
    output SPI_WR, SYS_TIME_UPDATE, TIME, FREQ, FREQ_STEP, FREQ_RATE, TIME_START,
           N_impulse, TYPE_impulse, Interval_Ti, Interval_Tp, Tblank1, Tblank2,
    input  SYS_TIME, IMP, BLANK, FREQ_OUT, FREQ_VALID, BUSY, DONE
  );

  modport slave (
    input  SPI_WR, SYS_TIME_UPDATE, TIME, FREQ, FREQ_STEP, FREQ_RATE, TIME_START,
           N_impulse, TYPE_impulse, Interval_Ti, Interval_Tp, Tblank1, Tblank2,
    output SYS_TIME, IMP, BLANK, FREQ_OUT, FREQ_VALID, BUSY, DONE
  );

endinterface

// File: rtl/impulse_sequencer_freq_stepper.sv
// Carrier frequency stepper: accumulator advanced by step_size_i once every
// rate_i pulses (rate_i = 0 keeps the start frequency).
//   load_i      : restart at freq_i (first pulse of a burst / pulse index wrap)
//   step_i      : advance to the next pulse
//   freq_o      : frequency word of the current pulse, held otherwise
module freq_stepper
  import imp_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [FREQ_W-1:0] freq_i,
  input  logic [FREQ_W-1:0] step_size_i,
  input  logic [INT_W-1:0]  rate_i,
  output logic [FREQ_W-1:0] freq_o
);

  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [INT_W-1:0]  rcnt_q, rcnt_d;

  // rcnt counts pulses already emitted at the current frequency
  always_comb begin
    freq_d = freq_q;
    rcnt_d = rcnt_q;
    if (load_i) begin
      freq_d = freq_i;
      rcnt_d = '0;
    end else if (step_i && (rate_i != '0)) begin
      if (rcnt_q == rate_i - INT_W'(1)) begin
        freq_d = freq_q + step_size_i;
        rcnt_d = '0;
      end else begin
        rcnt_d = rcnt_q + INT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      freq_q <= '0;
      rcnt_q <= '0;
    end else begin
      freq_q <= freq_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign freq_o = freq_q;

endmodule

// File: rtl/impulse_sequencer.sv
// Impulse sequencer: keeps system time, latches SPI parameter packets and
// generates timed probing-pulse bursts with blanking gate and stepped carrier.
//   clk, rst_n : clock, asynchronous active-low reset
//   clk_en     : global clock enable (all state holds when low)
//   bus        : packet inputs and pulse/status outputs (slave side)
module impulse_sequencer
  import imp_seq_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  impulse_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] sys_time_q, sys_time_d;
  prm_t              prm_q, prm_d, pkt_c;
  logic [INT_W-1:0]  cnt_q, cnt_d;
  logic [NIMP_W-1:0] k_q, k_d;
  logic              imp_q, imp_d;
  logic              blank_q, blank_d;
  logic              fv_q, fv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              load_c, step_c;

  logic              stop_c, cont_c, last_k_c;
  logic [INT_W-1:0]  tp_eff_c, tp_last_c;
  logic [INT_W:0]    blank1_end_c, blank2_start_c;

  assign pkt_c = '{
    freq:         bus.FREQ,
    freq_step:    bus.FREQ_STEP,
    freq_rate:    bus.FREQ_RATE,
    time_start:   bus.TIME_START,
    n_impulse:    bus.N_impulse,
    type_impulse: bus.TYPE_impulse,
    ti:           bus.Interval_Ti,
    tp:           bus.Interval_Tp,
    tblank1:      bus.Tblank1,
    tblank2:      bus.Tblank2
  };

  // N=0 in burst mode is the stop command
  assign stop_c    = (bus.N_impulse == '0) && !bus.TYPE_impulse[TYPE_CONT];
  assign cont_c    = prm_q.type_impulse[TYPE_CONT];
  assign last_k_c  = (k_q == prm_q.n_impulse - NIMP_W'(1));
  assign tp_eff_c  = eff_period(prm_q.tp);
  assign tp_last_c = tp_eff_c - INT_W'(1);

  // One extra bit keeps Ti+Tblank1 from wrapping; Tblank2 >= Tp blanks all
  assign blank1_end_c   = {1'b0, prm_q.ti} + {1'b0, prm_q.tblank1};
  assign blank2_start_c = (prm_q.tblank2 >= tp_eff_c) ? '0
                        : ({1'b0, tp_eff_c} - {1'b0, prm_q.tblank2});

  // Next state, counters and registered outputs (computed from next counters)
  always_comb begin
    state_d    = state_q;
    sys_time_d = sys_time_q;
    prm_d      = prm_q;
    cnt_d      = cnt_q;
    k_d        = k_q;
    imp_d      = imp_q;
    blank_d    = blank_q;
    busy_d     = busy_q;
    fv_d       = 1'b0;
    done_d     = 1'b0;
    load_c     = 1'b0;
    step_c     = 1'b0;

    if (clk_en) begin
      sys_time_d = (bus.SPI_WR && bus.SYS_TIME_UPDATE) ? bus.TIME
                                                       : sys_time_q + TIME_W'(1);
      if (bus.SPI_WR) begin
        prm_d   = pkt_c;
        state_d = stop_c ? IDLE : ARM;
      end else begin
        case (state_q)
          ARM: begin
            if (sys_time_q >= prm_q.time_start) begin
              state_d = RUN;
              cnt_d   = '0;
              k_d     = '0;
              load_c  = 1'b1;
            end
          end
          RUN: begin
            if (cnt_q >= tp_last_c) begin
              cnt_d = '0;
              if (!cont_c && last_k_c) begin
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                k_d = k_q + NIMP_W'(1);
                // k wraps to 0: frequency sequence restarts with it
                if (k_q == '1) load_c = 1'b1;
                else           step_c = 1'b1;
              end
            end else begin
              cnt_d = cnt_q + INT_W'(1);
            end
          end
          default: ;
        endcase
      end

      busy_d = (state_d != IDLE);
      if (state_d == RUN) begin
        imp_d   = (cnt_d < prm_q.ti);
        blank_d = ({1'b0, cnt_d} < blank1_end_c) || ({1'b0, cnt_d} >= blank2_start_c);
        fv_d    = (cnt_d == '0);
      end else begin
        imp_d   = 1'b0;
        blank_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sys_time_q <= '0;
      prm_q      <= '0;
      cnt_q      <= '0;
      k_q        <= '0;
      imp_q      <= 1'b0;
      blank_q    <= 1'b0;
      fv_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sys_time_q <= sys_time_d;
      prm_q      <= prm_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      imp_q      <= imp_d;
      blank_q    <= blank_d;
      fv_q       <= fv_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  freq_stepper u_freq_stepper (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load_c),
    .step_i      (step_c),
    .freq_i      (prm_q.freq),
    .step_size_i (prm_q.freq_step),
    .rate_i      (prm_q.freq_rate),
    .freq_o      (bus.FREQ_OUT)
  );

  assign bus.SYS_TIME   = sys_time_q;
  assign bus.IMP        = imp_q;
  assign bus.BLANK      = blank_q;
  assign bus.FREQ_VALID = fv_q;
  assign bus.BUSY       = busy_q;
  assign bus.DONE       = done_q;

endmodule

// File: doc/impulse_sequencer.md
Name: impulse_sequencer

Overview:
- Downstream consumer of the 51-byte SPI parameter packet decoder (`DMA_SPI`).
- Keeps the FPGA system-time counter and, on each `SPI_WR`, latches the packet fields.
- Waits until system time reaches `TIME_START`, then generates `N_impulse` probing pulses with their blanking gate.
- Presents a stepped carrier-frequency word per pulse to the synthesizer control stage.

Parameters:
- `TIME_W`, 64, width of the system time and `TIME_START` fields.
- `FREQ_W`, 48, width of the frequency words.
- `INT_W`, 32, width of the `Interval_Ti`, `Interval_Tp`, `Tblank1`, `Tblank2` and `FREQ_RATE` fields.

Ports:
- `clk`  in  1  system clock (48 MHz).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clk_en`  in  1  clock enable; all state advances only when it is 1.
- `SPI_WR`  in  1  one-cycle strobe: packet fields valid.
- `SYS_TIME_UPDATE`  in  1  qualifies `SPI_WR`: load `TIME` into the system counter.
- `TIME`  in  `TIME_W`  new system time value.
- `FREQ`  in  `FREQ_W`  start frequency word.
- `FREQ_STEP`  in  `FREQ_W`  frequency increment.
- `FREQ_RATE`  in  `INT_W`  pulses per frequency step; 0 = no stepping.
- `TIME_START`  in  `TIME_W`  start time of the burst.
- `N_impulse`  in  16  pulse count.
- `TYPE_impulse`  in  8  mode; bit0 = continuous; bits 7:1 latched, reserved.
- `Interval_Ti`  in  `INT_W`  pulse width, clocks.
- `Interval_Tp`  in  `INT_W`  pulse period, clocks.
- `Tblank1`  in  `INT_W`  post-pulse blanking, clocks.
- `Tblank2`  in  `INT_W`  pre-pulse blanking, clocks.
- `SYS_TIME`  out  `TIME_W`  system time counter.
- `IMP`  out  1  pulse gate.
- `BLANK`  out  1  receiver blanking gate.
- `FREQ_OUT`  out  `FREQ_W`  current pulse frequency word.
- `FREQ_VALID`  out  1  one-cycle strobe on each pulse start.
- `BUSY`  out  1  state is ARM or RUN.
- `DONE`  out  1  one-cycle strobe at burst end.

Behaviour:
- **Reset:** every output is 0; state is IDLE; all latched fields are 0.
- **Clock enable:** when `clk_en`=0 all registers hold, including `SYS_TIME`, and strobes are suppressed.
- **System time:** `SYS_TIME` increments by 1 each enabled cycle and wraps modulo 2^`TIME_W`.
  - If `SPI_WR` and `SYS_TIME_UPDATE` are both 1, it loads `TIME` instead of incrementing, so `SYS_TIME`=`TIME` on the next cycle.
- **Parameter latch:** `SPI_WR` in any state latches all fields and goes to ARM.
  - A burst in progress is aborted: `IMP`/`BLANK` drop on the next cycle and `DONE` is not pulsed.
  - If the latched `N_impulse`=0 and `TYPE_impulse`[0]=0, go to IDLE instead of ARM. This is the stop command.
- **State machine:**
  - IDLE: wait for `SPI_WR`.
  - ARM → RUN on the first enabled edge with `SYS_TIME` >= `TIME_START` (unsigned). A `TIME_START` already in the past therefore starts on the next edge. On entry, cnt=0 and k=0.
  - RUN: cnt counts 0..Tp-1.
    - At cnt=Tp-1, k increments and cnt=0.
    - After impulse k=N-1 completes, go to IDLE with `DONE`=1 for one cycle.
    - With `TYPE_impulse`[0]=1, RUN repeats until the next `SPI_WR`.
- **Latency:** if `SYS_TIME` shows value S in ARM and S >= `TIME_START`, then `IMP`=1 from the cycle where `SYS_TIME`=S+1.
- **Outputs in RUN:**
  - `IMP` = (cnt < Ti).
  - `BLANK` = (cnt < Ti+Tblank1) OR (cnt >= Tp-Tblank2). Sums and differences are computed `INT_W`+1 bits wide and saturated: a Ti+Tblank1 overflow means "whole period"; Tblank2 >= Tp means "whole period".
  - `IMP` and `BLANK` are 0 outside RUN.
- **Degenerate intervals:** Tp=0 is treated as Tp=1; Ti >= Tp means `IMP` is high for the whole period.
- **Frequency:**
  - At cnt=0 of impulse k, `FREQ_OUT` = `FREQ` + `FREQ_STEP`·floor(k/`FREQ_RATE`), modulo 2^`FREQ_W`. Implemented as an accumulator plus rate counter; no multiplier.
  - With `FREQ_RATE`=0, `FREQ_OUT` = `FREQ` for all pulses.
  - `FREQ_VALID` is high in the same cycle as the first `IMP` cycle of each pulse.
  - `FREQ_OUT` holds its value in IDLE.
- **Pulse counter:** k is 16 bits and wraps in continuous mode.

Decomposition:
- Shared package `imp_seq_pkg`:
  - state enum {IDLE, ARM, RUN};
  - `TYPE_impulse` bit index constants (`TYPE_CONT`=0);
  - width constants `TIME_W`, `FREQ_W`, `INT_W`.
- One sub-module, `freq_stepper`:
  - function: `FREQ` accumulator and rate counter;
  - inputs: load, step-enable;
  - outputs: `FREQ_OUT`.

Test Plan:
- **Basic burst:** `SPI_WR` with `SYS_TIME_UPDATE`=1, `TIME`=0, `TIME_START`=100, N=3, Ti=5, Tp=20, Tblank1=2, Tblank2=3, `FREQ`=1, `FREQ_STEP`=2, `FREQ_RATE`=1 →
  - `IMP` high while `SYS_TIME` is 101–105, 121–125 and 141–145;
  - `BLANK` high while `SYS_TIME` is 101–107 and 118–127;
  - `FREQ_OUT` = 1, 3, 5;
  - `DONE` high at `SYS_TIME`=161; `BUSY` then 0.
- **Step rate:** `FREQ_RATE`=2, N=5, `FREQ`=10, `FREQ_STEP`=1 → `FREQ_OUT` = 10, 10, 11, 11, 12.
- **Start in the past:** `TIME_START`=5 while `SYS_TIME`=1000 → `IMP` rises 2 cycles after `SPI_WR`.
- **Abort and stop:** `SPI_WR` mid-pulse with N=0, `TYPE_impulse`=0 → `IMP`/`BLANK` drop next cycle, state IDLE, no `DONE`.
- **Continuous mode:** `TYPE_impulse`=1, N=2 → more than 10 pulses, no `DONE`.
- **Freeze and reset:** `clk_en` low for 7 cycles mid-pulse → `SYS_TIME` and pulse phase stall 7 cycles; `rst_n` low mid-burst → all outputs 0 immediately (asynchronous).
